// File: rtl/raycast_pkg.sv
// Shared raycaster constants: map geometry, default wall layout and tile indexing.
package raycast_pkg;

    localparam int MAP_DIM   = 16;
    localparam int MAP_BITS  = 4;
    localparam int MAP_CELLS = MAP_DIM * MAP_DIM;

    // Row y occupies bits [y*16+15 : y*16]; MSB row is y=15. Perimeter walls plus a pillar at (8,8).
    localparam logic [MAP_CELLS-1:0] DEFAULT_MAP =
        256'hFFFF_8001_8001_8001_8001_8001_8001_8101_8001_8001_8001_8001_8001_8001_8001_FFFF;

    function automatic logic [2*MAP_BITS-1:0] tile_index(
        input logic [MAP_BITS-1:0] x,
        input logic [MAP_BITS-1:0] y
    );
        return {y, x};
    endfunction

endpackage

// File: rtl/world_map_rom.sv
// Combinational read of the fixed wall bitmap; one bit per tile, 1 = wall.
module world_map_rom
    import raycast_pkg::*;
#(
    parameter int                         MAP_W    = MAP_DIM,
    parameter int                         MAP_H    = MAP_DIM,
    parameter logic [MAP_W*MAP_H-1:0]     MAP_INIT = DEFAULT_MAP
) (
    input  logic [MAP_BITS-1:0] x,
    input  logic [MAP_BITS-1:0] y,
    output logic                wall
);

    logic [2*MAP_BITS-1:0] idx;

    assign idx  = tile_index(x, y);
    assign wall = MAP_INIT[idx];

endmodule

// File: rtl/world_map.sv
// Tile-map wall lookup for the DDA stepper, plus a latch holding the first wall hit of each ray.
module world_map
    import raycast_pkg::*;
#(
    parameter int                     MAP_W    = MAP_DIM,
    parameter int                     MAP_H    = MAP_DIM,
    parameter logic [MAP_W*MAP_H-1:0] MAP_INIT = DEFAULT_MAP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [MAP_BITS-1:0] xPos,
    input  logic [MAP_BITS-1:0] yPos,
    input  logic                setup_complete,
    input  logic                is_new_ray,
    output logic                is_wall,
    output logic [MAP_BITS-1:0] hit_coord_x,
    output logic [MAP_BITS-1:0] hit_coord_y
);

    logic                tile_wall;
    logic                wall_hit;
    logic                hit_valid_q, hit_valid_d;
    logic [MAP_BITS-1:0] hit_x_q, hit_x_d;
    logic [MAP_BITS-1:0] hit_y_q, hit_y_d;

    world_map_rom #(
        .MAP_W    (MAP_W),
        .MAP_H    (MAP_H),
        .MAP_INIT (MAP_INIT)
    ) u_rom (
        .x    (xPos),
        .y    (yPos),
        .wall (tile_wall)
    );

    // Zero-latency so the stepper can stop in the same cycle it enters a wall cell.
    assign wall_hit = setup_complete & tile_wall;
    assign is_wall  = wall_hit;

    // A new ray wins over capture; once valid, later walls from stepper overshoot are ignored.
    always_comb begin
        hit_valid_d = hit_valid_q;
        hit_x_d     = hit_x_q;
        hit_y_d     = hit_y_q;
        if (is_new_ray) begin
            hit_valid_d = 1'b0;
            hit_x_d     = '0;
            hit_y_d     = '0;
        end else if (wall_hit && !hit_valid_q) begin
            hit_valid_d = 1'b1;
            hit_x_d     = xPos;
            hit_y_d     = yPos;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_valid_q <= 1'b0;
            hit_x_q     <= '0;
            hit_y_q     <= '0;
        end else begin
            hit_valid_q <= hit_valid_d;
            hit_x_q     <= hit_x_d;
            hit_y_q     <= hit_y_d;
        end
    end

    assign hit_coord_x = hit_x_q;
    assign hit_coord_y = hit_y_q;

endmodule

// File: tb/tb_world_map.sv
// Self-checking bench for world_map: wall lookup gating, first-hit latch, new-ray priority, async reset.
module tb_world_map;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] xPos;
    logic [3:0] yPos;
    logic       setup_complete;
    logic       is_new_ray;
    logic       is_wall;
    logic [3:0] hit_coord_x;
    logic [3:0] hit_coord_y;

    int total = 0;
    int bad   = 0;

    // Expected latch contents, packed {y, x}, pushed when stimulus is driven.
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    world_map dut (
        .clk            (clk),
        .reset          (reset),
        .xPos           (xPos),
        .yPos           (yPos),
        .setup_complete (setup_complete),
        .is_new_ray     (is_new_ray),
        .is_wall        (is_wall),
        .hit_coord_x    (hit_coord_x),
        .hit_coord_y    (hit_coord_y)
    );

    // Independent description of the default layout: perimeter plus pillar at (8,8).
    function automatic logic wall_model(input int x, input int y);
        return (x == 0) || (x == 15) || (y == 0) || (y == 15) || (x == 8 && y == 8);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        reset          = 1'b1;
        setup_complete = 1'b0;
        is_new_ray     = 1'b0;
        xPos           = 4'd0;
        yPos           = 4'd0;
        #2;
        exp_q.push_back(8'h00);
        e = exp_q.pop_front();
        total++;
        if ({hit_coord_y, hit_coord_x} !== e) begin
            bad++;
            $display("FAIL reset_coords: got (%0d,%0d) want (%0d,%0d)",
                     hit_coord_x, hit_coord_y, e[3:0], e[7:4]);
        end
        total++;
        if (is_wall !== 1'b0) begin
            bad++;
            $display("FAIL reset_is_wall_gated: got %b want 0", is_wall);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_gate();
        logic [7:0] e;
        xPos           = 4'd0;
        yPos           = 4'd5;
        setup_complete = 1'b0;
        #1;
        total++;
        if (is_wall !== 1'b0) begin
            bad++;
            $display("FAIL gate_off: got %b want 0", is_wall);
        end
        setup_complete = 1'b1;
        #1;
        total++;
        if (is_wall !== 1'b1) begin
            bad++;
            $display("FAIL gate_on: got %b want 1", is_wall);
        end
        exp_q.push_back({4'd5, 4'd0});
        tick();
        e = exp_q.pop_front();
        total++;
        if ({hit_coord_y, hit_coord_x} !== e) begin
            bad++;
            $display("FAIL gate_capture: got (%0d,%0d) want (%0d,%0d)",
                     hit_coord_x, hit_coord_y, e[3:0], e[7:4]);
        end
    endtask

    task automatic test_interior();
        logic [7:0] e;
        is_new_ray = 1'b1;
        xPos       = 4'd5;
        yPos       = 4'd5;
        exp_q.push_back(8'h00);
        tick();
        is_new_ray = 1'b0;
        e = exp_q.pop_front();
        total++;
        if ({hit_coord_y, hit_coord_x} !== e) begin
            bad++;
            $display("FAIL interior_clear: got (%0d,%0d) want (%0d,%0d)",
                     hit_coord_x, hit_coord_y, e[3:0], e[7:4]);
        end
        for (int i = 5; i <= 7; i++) begin
            xPos = 4'(i);
            #1;
            total++;
            if (is_wall !== 1'b0) begin
                bad++;
                $display("FAIL interior_is_wall x=%0d: got %b want 0", i, is_wall);
            end
            exp_q.push_back(8'h00);
            tick();
            e = exp_q.pop_front();
            total++;
            if ({hit_coord_y, hit_coord_x} !== e) begin
                bad++;
                $display("FAIL interior_hold x=%0d: got (%0d,%0d) want (%0d,%0d)",
                         i, hit_coord_x, hit_coord_y, e[3:0], e[7:4]);
            end
        end
    endtask

    task automatic test_first_hit();
        logic [7:0] e;
        is_new_ray = 1'b1;
        tick();
        is_new_ray = 1'b0;
        xPos = 4'd8;
        yPos = 4'd8;
        #1;
        total++;
        if (is_wall !== 1'b1) begin
            bad++;
            $display("FAIL pillar_is_wall: got %b want 1", is_wall);
        end
        exp_q.push_back({4'd8, 4'd8});
        tick();
        e = exp_q.pop_front();
        total++;
        if ({hit_coord_y, hit_coord_x} !== e) begin
            bad++;
            $display("FAIL pillar_capture: got (%0d,%0d) want (%0d,%0d)",
                     hit_coord_x, hit_coord_y, e[3:0], e[7:4]);
        end
        xPos = 4'd15;
        #1;
        total++;
        if (is_wall !== 1'b1) begin
            bad++;
            $display("FAIL overshoot_is_wall: got %b want 1", is_wall);
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({4'd8, 4'd8});
            tick();
            e = exp_q.pop_front();
            total++;
            if ({hit_coord_y, hit_coord_x} !== e) begin
                bad++;
                $display("FAIL overshoot_hold %0d: got (%0d,%0d) want (%0d,%0d)",
                         i, hit_coord_x, hit_coord_y, e[3:0], e[7:4]);
            end
        end
    endtask

    task automatic test_new_ray_priority();
        logic [7:0] e;
        xPos       = 4'd15;
        yPos       = 4'd3;
        is_new_ray = 1'b1;
        #1;
        total++;
        if (is_wall !== 1'b1) begin
            bad++;
            $display("FAIL priority_is_wall: got %b want 1", is_wall);
        end
        exp_q.push_back(8'h00);
        tick();
        e = exp_q.pop_front();
        total++;
        if ({hit_coord_y, hit_coord_x} !== e) begin
            bad++;
            $display("FAIL priority_clear: got (%0d,%0d) want (%0d,%0d)",
                     hit_coord_x, hit_coord_y, e[3:0], e[7:4]);
        end
        is_new_ray = 1'b0;
        exp_q.push_back({4'd3, 4'd15});
        tick();
        e = exp_q.pop_front();
        total++;
        if ({hit_coord_y, hit_coord_x} !== e) begin
            bad++;
            $display("FAIL priority_recapture: got (%0d,%0d) want (%0d,%0d)",
                     hit_coord_x, hit_coord_y, e[3:0], e[7:4]);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] e;
        reset = 1'b1;
        #1;
        exp_q.push_back(8'h00);
        e = exp_q.pop_front();
        total++;
        if ({hit_coord_y, hit_coord_x} !== e) begin
            bad++;
            $display("FAIL async_clear: got (%0d,%0d) want (%0d,%0d)",
                     hit_coord_x, hit_coord_y, e[3:0], e[7:4]);
        end
        total++;
        if (is_wall !== 1'b1) begin
            bad++;
            $display("FAIL async_is_wall: got %b want 1", is_wall);
        end
        #2;
        reset = 1'b0;
        exp_q.push_back({4'd3, 4'd15});
        tick();
        e = exp_q.pop_front();
        total++;
        if ({hit_coord_y, hit_coord_x} !== e) begin
            bad++;
            $display("FAIL async_recapture: got (%0d,%0d) want (%0d,%0d)",
                     hit_coord_x, hit_coord_y, e[3:0], e[7:4]);
        end
    endtask

    // Several short rays back to back: {new_ray, x, y, expected {y,x} after the edge}.
    task automatic test_back_to_back();
        logic [7:0]  e;
        logic [16:0] steps [8];
        steps[0] = {1'b1, 4'd14, 4'd14, 8'h00};
        steps[1] = {1'b0, 4'd14, 4'd14, 8'h00};
        steps[2] = {1'b0, 4'd15, 4'd14, {4'd14, 4'd15}};
        steps[3] = {1'b1, 4'd0,  4'd14, 8'h00};
        steps[4] = {1'b0, 4'd1,  4'd14, 8'h00};
        steps[5] = {1'b0, 4'd0,  4'd14, {4'd14, 4'd0}};
        steps[6] = {1'b1, 4'd3,  4'd1,  8'h00};
        steps[7] = {1'b0, 4'd3,  4'd0,  {4'd0, 4'd3}};
        for (int i = 0; i < 8; i++) begin
            is_new_ray = steps[i][16];
            xPos       = steps[i][15:12];
            yPos       = steps[i][11:8];
            exp_q.push_back(steps[i][7:0]);
            tick();
            e = exp_q.pop_front();
            total++;
            if ({hit_coord_y, hit_coord_x} !== e) begin
                bad++;
                $display("FAIL back_to_back step %0d: got (%0d,%0d) want (%0d,%0d)",
                         i, hit_coord_x, hit_coord_y, e[3:0], e[7:4]);
            end
        end
        is_new_ray = 1'b0;
    endtask

    task automatic test_map_sweep();
        logic want;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                xPos           = 4'(x);
                yPos           = 4'(y);
                setup_complete = 1'b1;
                #1;
                want = wall_model(x, y);
                total++;
                if (is_wall !== want) begin
                    bad++;
                    $display("FAIL map_sweep (%0d,%0d): got %b want %b", x, y, is_wall, want);
                end
                setup_complete = 1'b0;
                #1;
                total++;
                if (is_wall !== 1'b0) begin
                    bad++;
                    $display("FAIL map_sweep_gated (%0d,%0d): got %b want 0", x, y, is_wall);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_gate();
        test_interior();
        test_first_hit();
        test_new_ray_priority();
        test_async_reset();
        test_back_to_back();
        test_map_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/world_map.md
Name: world_map

Overview:
- Tile-map lookup block for the raycaster: a fixed 16x16 grid of 1-bit wall tiles.
- The DDA stepper in ray_calculator drives the current map cell (xPos, yPos). The block answers combinationally whether that cell is a wall.
- It latches the coordinates of the first wall hit of each ray for downstream texture and column logic.
- Sits directly under ray_calculator. Pure lookup plus one small latch; no arithmetic.

Parameters:
- MAP_W, 16, map width in tiles (fixed to 16; coordinates are 4 bits).
- MAP_H, 16, map height in tiles (fixed to 16).
- MAP_INIT, 256'h(default layout below), wall bitmap; bit index = yPos*16 + xPos, 1 = wall.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears the hit latch.
- xPos  input  4  current map cell column (mapX from stepper).
- yPos  input  4  current map cell row (mapY from stepper).
- setup_complete  input  1  ray setup finished; stepper is walking the grid.
- is_new_ray  input  1  single-cycle pulse at start of each ray.
- is_wall  output  1  combinational: current cell is a wall and setup_complete=1.
- hit_coord_x  output  4  registered column of first wall hit of current ray.
- hit_coord_y  output  4  registered row of first wall hit of current ray.

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous and active-high.
- Map storage: read-only 256-bit vector initialised from MAP_INIT. It is not writable at runtime.
- Default MAP_INIT layout:
  - all perimeter cells are walls (x=0, x=15, y=0, y=15);
  - the single interior pillar at (8,8) is a wall;
  - all other cells are empty.
- is_wall = setup_complete & MAP[{yPos,xPos}].
  - Purely combinational, zero latency, so the stepper sees the wall in the same cycle it enters the cell.
  - With setup_complete=0, is_wall=0 regardless of cell.
- Hit latch: internal register hit_valid plus hit_coord_x/hit_coord_y.
  - Reset (async): hit_valid=0, hit_coord_x=0, hit_coord_y=0.
  - On rising clk with is_new_ray=1: hit_valid<=0 and coords<=0. This has priority over capture in the same cycle.
  - Else, if is_wall=1 and hit_valid=0: hit_coord_x<=xPos, hit_coord_y<=yPos, hit_valid<=1. Coordinates are valid one cycle after is_wall first asserts.
  - Else: hold. Later wall cells in the same ray (stepper overshoot) must not overwrite the latch.
- Coordinates are 4-bit, so every index is in range; there is no out-of-bounds case. Perimeter walls guarantee termination of any ray.
- Reset asserted mid-ray: the latch clears immediately. is_wall still follows its inputs, since it is combinational.

Decomposition:
- Shared package raycast_pkg:
  - MAP_DIM=16 and MAP_BITS=4;
  - default map constant DEFAULT_MAP (256 bits);
  - helper function tile_index(x,y) = {y,x}.
- No sub-module required.
- Optional natural split: world_map_rom (combinational bitmap read) instantiated by world_map, with the latch kept in the top.

Test Plan:
- Reset: assert reset with clk idle -> hit_coord_x=0, hit_coord_y=0 immediately; is_wall=0 with setup_complete=0.
- Gate: setup_complete=0, (xPos,yPos)=(0,5) -> is_wall=0. Raise setup_complete=1 -> is_wall=1 same cycle. Next edge -> hit_coord=(0,5).
- Interior: setup_complete=1, walk (5,5),(6,5),(7,5) -> is_wall=0 throughout; hit_coord stays 0.
- First-hit hold: pulse is_new_ray, then step to (8,8) -> is_wall=1 and hit_coord=(8,8) after one edge. Then drive (15,8) -> is_wall=1 but hit_coord remains (8,8).
- New-ray priority: with latch=(8,8), drive is_new_ray=1 while at wall (15,3) -> after edge hit_coord=(0,0). Next cycle with is_new_ray=0 at (15,3) -> hit_coord=(15,3).
- Async reset mid-ray: latch=(15,3), assert reset between edges -> hit_coord=(0,0) without a clock edge. Deassert, still at wall (15,3) -> recapture (15,3) on next edge.
